divshare_ctrl: RTL and testbench

Sequencer and arbiter for the shared digit-recurrence divider when integer division is executed on the FPU divider (IDIV_ON_FPU = 1). Accepts divide/sqrt requests from the FPU and integer divide requests from the IEU, grants the divider to one requester at a time with round-robin priority, and issues load and iterate enables for a fixed iteration count per operation class. It sits in the Execute stage beside the divsqrt datapath. It owns early termination, flush abort and result hold under stall.

---
 rtl/divshare_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_divshare_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/divshare_ctrl.sv
// ---------------------------------------------------------------------------
// divshare_ctrl
//
// Sequencer and arbiter for the shared digit-recurrence divider when integer
// division runs on the FPU divider. It grants the divider to the FPU
// (div/sqrt) or the IEU (integer divide) with round-robin priority on ties.
// It issues the operand-load and iterate enables for a fixed iteration count
// per operation class, and flags the result as valid when the count expires.
// It also handles early termination for special operands, flush abort while
// iterating, and holding the result while the Memory stage is stalled.
//
// Parameters
//   DURLEN        width of the iteration counter
//   FPDUR         iterations for an FP divide/sqrt (1 .. 2^DURLEN-1)
//   IDUR          iterations for an integer divide (1 .. 2^DURLEN-1)
//
// Ports
//   i_clk           clock, rising edge
//   i_reset         synchronous active-high reset
//   i_fp_req        FPU div/sqrt request (level, held until granted)
//   i_fp_special    FP operands are a special case (NaN/Inf/zero)
//   i_int_req       IEU integer divide request (level, held until granted)
//   i_int_zero_div  integer divisor is zero
//   i_flush_e       Execute-stage flush
//   i_stall_m       Memory stage stalled, result must be held
//   o_fp_gnt        FP request accepted (one-cycle pulse)
//   o_int_gnt       integer request accepted (one-cycle pulse)
//   o_init_en       load operands into the divider
//   o_iter_en       advance the recurrence one step
//   o_owner_fp      current/last operation is FP (1) or integer (0)
//   o_busy          controller not idle
//   o_fp_done       FP result valid
//   o_int_done      integer result valid
//   o_iter_count    remaining iterations
// ---------------------------------------------------------------------------
module divshare_ctrl #(
  parameter int DURLEN = 5,
  parameter int FPDUR  = 18,
  parameter int IDUR   = 17
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fp_req,
  input  logic              i_fp_special,
  input  logic              i_int_req,
  input  logic              i_int_zero_div,
  input  logic              i_flush_e,
  input  logic              i_stall_m,
  output logic              o_fp_gnt,
  output logic              o_int_gnt,
  output logic              o_init_en,
  output logic              o_iter_en,
  output logic              o_owner_fp,
  output logic              o_busy,
  output logic              o_fp_done,
  output logic              o_int_done,
  output logic [DURLEN-1:0] o_iter_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [DURLEN-1:0] FP_LOAD  = DURLEN'(FPDUR);
  localparam logic [DURLEN-1:0] INT_LOAD = DURLEN'(IDUR);
  localparam logic [DURLEN-1:0] CNT_ZERO = {DURLEN{1'b0}};
  localparam logic [DURLEN-1:0] CNT_ONE  = {{(DURLEN-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DURLEN-1:0]  r_count;
  logic [DURLEN-1:0]  w_count_nxt;
  logic               r_last_fp;
  logic               w_last_fp_nxt;
  logic               r_owner_fp;
  logic               w_owner_fp_nxt;
  logic               w_fp_win;
  logic               w_int_win;
  logic               w_active;

  // Outputs are forced low while reset is held, even before the state
  // register has been cleared by the first reset edge.
  assign w_active = ~i_reset;

  // Round-robin arbitration, only in IDLE and never during a flush.
  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    w_fp_win  = 1'b0;
    w_int_win = 1'b0;
    if (w_active && (r_state == S_IDLE) && !i_flush_e) begin
      if (i_fp_req && i_int_req) begin
        w_fp_win  = ~r_last_fp;
        w_int_win = r_last_fp;
      end else begin
        w_fp_win  = i_fp_req;
        w_int_win = i_int_req;
      end
    end else begin
      w_fp_win  = 1'b0;
      w_int_win = 1'b0;
    end
  end

  // Next-state, counter and ownership logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_last_fp_nxt  = r_last_fp;
    w_owner_fp_nxt = r_owner_fp;
    case (r_state)
      S_IDLE: begin
        if (w_fp_win) begin
          w_owner_fp_nxt = 1'b1;
          w_last_fp_nxt  = 1'b1;
          if (i_fp_special) begin
            // Special operands bypass the recurrence entirely.
            w_state_nxt = S_DONE;
            w_count_nxt = CNT_ZERO;
          end else begin
            w_state_nxt = S_BUSY;
            w_count_nxt = FP_LOAD;
          end
        end else if (w_int_win) begin
          w_owner_fp_nxt = 1'b0;
          w_last_fp_nxt  = 1'b0;
          if (i_int_zero_div) begin
            w_state_nxt = S_DONE;
            w_count_nxt = CNT_ZERO;
          end else begin
            w_state_nxt = S_BUSY;
            w_count_nxt = INT_LOAD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (i_flush_e) begin
          // Abort: the partial result is discarded, no Done is raised.
          w_state_nxt = S_IDLE;
          w_count_nxt = CNT_ZERO;
        end else if (r_count <= CNT_ONE) begin
          // Last iteration this cycle; the "<=" also recovers from a
          // corrupted zero count instead of wrapping around.
          w_state_nxt = S_DONE;
          w_count_nxt = CNT_ZERO;
        end else begin
          w_count_nxt = r_count - CNT_ONE;
        end
      end
      S_DONE: begin
        // Flush is ignored here: the result already belongs to M.
        if (i_stall_m) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = CNT_ZERO;
      end
    endcase
  end

  // State, counter and ownership registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_count    <= CNT_ZERO;
      r_last_fp  <= 1'b1;
      r_owner_fp <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_last_fp  <= w_last_fp_nxt;
      r_owner_fp <= w_owner_fp_nxt;
    end
  end

  assign o_fp_gnt     = w_fp_win;
  assign o_int_gnt    = w_int_win;
  assign o_init_en    = w_fp_win | w_int_win;
  assign o_iter_en    = w_active & (r_state == S_BUSY);
  assign o_owner_fp   = w_active & r_owner_fp;
  assign o_busy       = w_active & (r_state != S_IDLE);
  assign o_fp_done    = w_active & (r_state == S_DONE) & r_owner_fp;
  assign o_int_done   = w_active & (r_state == S_DONE) & ~r_owner_fp;
  assign o_iter_count = w_active ? r_count : CNT_ZERO;

endmodule

// File: tb/tb_divshare_ctrl.sv
// ---------------------------------------------------------------------------
// tb_divshare_ctrl
//
// Directed bench for divshare_ctrl. Inputs change 1 time unit after a rising
// edge and outputs are compared on the following falling edge. A short
// vector table covers reset, early termination, flush in IDLE/DONE and tie
// breaking; hand-written loops cover the long iterate sequences, stall hold,
// flush abort and reset in the middle of an operation.
// Input vector order:  {reset, fp_req, fp_special, int_req, int_zero, flush, stall}
// Output vector order: {fp_gnt, int_gnt, iter_en, owner_fp, busy, fp_done, int_done}
// ---------------------------------------------------------------------------
module tb_divshare_ctrl;

  logic       clk;
  logic       reset;
  logic       fp_req;
  logic       fp_special;
  logic       int_req;
  logic       int_zero;
  logic       flush;
  logic       stall;
  logic       fp_gnt;
  logic       int_gnt;
  logic       init_en;
  logic       iter_en;
  logic       owner_fp;
  logic       busy;
  logic       fp_done;
  logic       int_done;
  logic [4:0] iter_count;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [6:0] vin;
    logic [6:0] vex;
    logic [4:0] vcnt;
  } vec_t;

  vec_t tbl [13];

  divshare_ctrl #(
    .DURLEN (5),
    .FPDUR  (18),
    .IDUR   (17)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_fp_req       (fp_req),
    .i_fp_special   (fp_special),
    .i_int_req      (int_req),
    .i_int_zero_div (int_zero),
    .i_flush_e      (flush),
    .i_stall_m      (stall),
    .o_fp_gnt       (fp_gnt),
    .o_int_gnt      (int_gnt),
    .o_init_en      (init_en),
    .o_iter_en      (iter_en),
    .o_owner_fp     (owner_fp),
    .o_busy         (busy),
    .o_fp_done      (fp_done),
    .o_int_done     (int_done),
    .o_iter_count   (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, compare outputs and invariants, advance.
  task automatic step(input logic [6:0] vin, input logic [6:0] vex,
                      input logic [4:0] vcnt, input string nm);
    logic [12:0] act;
    logic [12:0] exp;
    logic        inv_ok;
    {reset, fp_req, fp_special, int_req, int_zero, flush, stall} = vin;
    @(negedge clk);
    act = {fp_gnt, int_gnt, init_en, iter_en, owner_fp, busy,
           fp_done, int_done, iter_count};
    exp = {vex[6], vex[5], vex[6] | vex[5], vex[4:0], vcnt};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gnt/init/iter/own/busy/done=%b cnt=%0d, expected %b cnt=%0d",
               nm, act[12:5], act[4:0], exp[12:5], exp[4:0]);
    end
    inv_ok = !(fp_gnt && int_gnt) && !(fp_done && int_done) &&
             !(iter_en && (!busy || fp_done || int_done)) &&
             !(init_en && busy);
    n_checks++;
    if (inv_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s invariant: gnt=%b%b done=%b%b iter=%b init=%b busy=%b",
               nm, fp_gnt, int_gnt, fp_done, int_done, iter_en, init_en, busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset, early termination, flush in IDLE/DONE, tie breaking.
    tbl[0]  = '{7'b1101000, 7'b0000000, 5'd0};  // reset held, requests masked
    tbl[1]  = '{7'b1000000, 7'b0000000, 5'd0};
    tbl[2]  = '{7'b0001100, 7'b0100000, 5'd0};  // int zero-div grant
    tbl[3]  = '{7'b0000000, 7'b0000101, 5'd0};  // IntDone at G+1
    tbl[4]  = '{7'b0110000, 7'b1000000, 5'd0};  // FP special grant
    tbl[5]  = '{7'b0000000, 7'b0001110, 5'd0};  // FpDone at G+1
    tbl[6]  = '{7'b0100010, 7'b0001000, 5'd0};  // flush in IDLE: no grant
    tbl[7]  = '{7'b0111100, 7'b0101000, 5'd0};  // tie, LastFp=1 -> int
    tbl[8]  = '{7'b0110011, 7'b0000101, 5'd0};  // DONE, flush+stall: held
    tbl[9]  = '{7'b0110010, 7'b0000101, 5'd0};  // DONE, flush ignored
    tbl[10] = '{7'b0111100, 7'b1000000, 5'd0};  // tie, LastFp=0 -> FP
    tbl[11] = '{7'b0000000, 7'b0001110, 5'd0};
    tbl[12] = '{7'b0000000, 7'b0001000, 5'd0};  // idle, owner holds
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].vin, tbl[i].vex, tbl[i].vcnt, $sformatf("tbl%0d", i));
    end

    // Lone FP divide: grant, 18 iterations counting 18..1, one Done cycle.
    step(7'b0100000, 7'b1001000, 5'd0, "fp_grant");
    for (int k = 1; k <= 18; k++) begin
      step(7'b0000000, 7'b0011100, 5'(19 - k), $sformatf("fp_iter%0d", k));
    end
    step(7'b0000000, 7'b0001110, 5'd0, "fp_done");
    step(7'b0000000, 7'b0001000, 5'd0, "fp_idle");

    // Reset then a held tie: integer first, then FP, then integer again.
    step(7'b1101000, 7'b0000000, 5'd0, "rr_reset");
    step(7'b0101000, 7'b0100000, 5'd0, "rr_tie1");
    for (int k = 1; k <= 17; k++) begin
      step(7'b0100000, 7'b0010100, 5'(18 - k), $sformatf("rr_int_iter%0d", k));
    end
    step(7'b0100000, 7'b0000101, 5'd0, "rr_int_done");
    step(7'b0100000, 7'b1000000, 5'd0, "rr_fp_grant");
    for (int k = 1; k <= 18; k++) begin
      step(7'b0101000, 7'b0011100, 5'(19 - k), $sformatf("rr_fp_iter%0d", k));
    end
    // Three stall cycles stretch FpDone to four cycles; pending requests wait.
    for (int k = 1; k <= 3; k++) begin
      step(7'b0101001, 7'b0001110, 5'd0, $sformatf("stall_done%0d", k));
    end
    step(7'b0101000, 7'b0001110, 5'd0, "stall_done4");
    step(7'b0101000, 7'b0101000, 5'd0, "rr_tie3");

    // Flush in the fifth BUSY cycle of the integer op.
    for (int k = 1; k <= 4; k++) begin
      step(7'b0000000, 7'b0010100, 5'(18 - k), $sformatf("fl_iter%0d", k));
    end
    step(7'b0000010, 7'b0010100, 5'd13, "fl_flush");
    step(7'b0000000, 7'b0000000, 5'd0, "fl_idle1");
    step(7'b0000000, 7'b0000000, 5'd0, "fl_idle2");

    // Reset while an integer op has 7 iterations left; LastFp returns to 1.
    step(7'b0001000, 7'b0100000, 5'd0, "rs_grant");
    for (int k = 1; k <= 10; k++) begin
      step(7'b0000000, 7'b0010100, 5'(18 - k), $sformatf("rs_iter%0d", k));
    end
    step(7'b1000000, 7'b0000000, 5'd0, "rs_reset");
    step(7'b0000000, 7'b0000000, 5'd0, "rs_idle");
    step(7'b0111100, 7'b0100000, 5'd0, "rs_tie");
    step(7'b0000000, 7'b0000101, 5'd0, "rs_done");
    step(7'b0000000, 7'b0000000, 5'd0, "rs_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
